// File: rtl/glift_seq_mult.sv
// Sequential shift-add multiplier with gate-level information flow tracking.
// Adds one partial-product row per cycle into a 2*WIDTH accumulator. Every
// accumulator bit carries a taint bit, computed through the same AND/XOR/OR
// gate structure as the value path.
// Build option: define GLIFT_CONSERVATIVE_EN to make every gate taint the OR
// of its input taints. This is cheaper, but it over-approximates taint. The
// value path is the same in both modes.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE, and in_valid is ignored in other states.
// out_valid stays high in DONE, with o/o_t held, until out_ready is seen.
module glift_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     a_t,
    input  logic [WIDTH-1:0]     b_t,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   o,
    output logic [2*WIDTH-1:0]   o_t,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [2*WIDTH-1:0] ROW_MASK = {{(WIDTH-1){1'b0}}, {(WIDTH+1){1'b1}}};

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_r, a_t_r, b_r, b_t_r;
    logic [2*WIDTH-1:0] acc, acc_t;
    logic [2*WIDTH-1:0] nxt_acc, nxt_acc_t;

    // Gate taint rules. Precise GLIFT is the default; the conservative build
    // ORs the input taints.
    function automatic logic and_t(input logic x, input logic xt, input logic y, input logic yt);
`ifdef GLIFT_CONSERVATIVE_EN
        and_t = xt | yt | (x & y & 1'b0);
`else
        and_t = (xt & yt) | (x & ~xt & yt) | (y & ~yt & xt);
`endif
    endfunction

    function automatic logic or_t(input logic x, input logic xt, input logic y, input logic yt);
`ifdef GLIFT_CONSERVATIVE_EN
        or_t = xt | yt | (x & y & 1'b0);
`else
        or_t = (xt & yt) | (~x & ~xt & yt) | (~y & ~yt & xt);
`endif
    endfunction

    function automatic logic xor_t(input logic xt, input logic yt);
        xor_t = xt | yt;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    // Add row cnt (a & b[cnt]) into accumulator bits cnt..cnt+WIDTH. Bits
    // outside that window pass through unchanged.
    always_comb begin
        logic [WIDTH-1:0]   sel;
        logic               b_bit, b_bit_t;
        logic [WIDTH-1:0]   win, win_t;
        logic [WIDTH:0]     res, res_t;
        logic [2*WIDTH-1:0] res_ext, res_t_ext, keep;
        logic               c, ct, pp, ppt, x, xt, xy, xyt, g1, g1t, g2, g2t;
        sel     = WIDTH'(1) << cnt;
        b_bit   = |(b_r & sel);
        b_bit_t = |(b_t_r & sel);
        win     = WIDTH'(acc >> cnt);
        win_t   = WIDTH'(acc_t >> cnt);
        res     = '0;
        res_t   = '0;
        c       = 1'b0;
        ct      = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            pp  = a_r[j] & b_bit;
            ppt = and_t(a_r[j], a_t_r[j], b_bit, b_bit_t);
            x   = win[j];
            xt  = win_t[j];
            xy  = x ^ pp;
            xyt = xor_t(xt, ppt);
            res[j]   = xy ^ c;
            res_t[j] = xor_t(xyt, ct);
            g1  = x & pp;
            g1t = and_t(x, xt, pp, ppt);
            g2  = c & xy;
            g2t = and_t(c, ct, xy, xyt);
            ct  = or_t(g1, g1t, g2, g2t);
            c   = g1 | g2;
        end
        res[WIDTH]   = c;
        res_t[WIDTH] = ct;
        res_ext   = {{(WIDTH-1){1'b0}}, res};
        res_t_ext = {{(WIDTH-1){1'b0}}, res_t};
        keep      = ~(ROW_MASK << cnt);
        nxt_acc   = (acc & keep)   | (res_ext << cnt);
        nxt_acc_t = (acc_t & keep) | (res_t_ext << cnt);
    end

    // Control FSM, operand latches, accumulator and result registers.
    // RUN spends WIDTH cycles adding rows. It then spends one more cycle
    // (cnt == WIDTH) publishing the accumulator to o/o_t as it enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            a_t_r <= '0;
            b_r   <= '0;
            b_t_r <= '0;
            acc   <= '0;
            acc_t <= '0;
            o     <= '0;
            o_t   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        a_t_r <= a_t;
                        b_r   <= b;
                        b_t_r <= b_t;
                        acc   <= '0;
                        acc_t <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        o     <= acc;
                        o_t   <= acc_t;
                        state <= DONE;
                    end else begin
                        acc   <= nxt_acc;
                        acc_t <= nxt_acc_t;
                        cnt   <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
